// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: default widths,
// fetch FSM state encoding and a helper that maps an address state to its
// byte offset within the fetched word.
package mem_ctrl_pkg;

  localparam int MC_RAM_AW = 17;
  localparam int MC_ADDR_W = 32;
  localparam int MC_INST_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_A0   = 3'd1,
    ST_A1   = 3'd2,
    ST_A2   = 3'd3,
    ST_A3   = 3'd4,
    ST_W    = 3'd5,
    ST_DONE = 3'd6
  } mc_state_e;

  // Byte offset presented to RAM in each address state; zero elsewhere.
  function automatic logic [1:0] fetch_offset(input mc_state_e st);
    logic [1:0] off;
    case (st)
      ST_A0:   off = 2'd0;
      ST_A1:   off = 2'd1;
      ST_A2:   off = 2'd2;
      ST_A3:   off = 2'd3;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

  // True for the states in which the fetch FSM owns the RAM address.
  function automatic logic fetch_drives(input mc_state_e st);
    logic drv;
    case (st)
      ST_A0, ST_A1, ST_A2, ST_A3: drv = 1'b1;
      default:                    drv = 1'b0;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: owns the single byte-wide RAM port. MEM stage byte
// requests pass straight through with no added latency; instruction fetches
// are sequenced into a pipelined 4-byte little-endian read. MEM always wins,
// aborting any fetch in flight except one already in DONE.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = MC_RAM_AW,
  parameter int ADDR_W = MC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [7:0]        mem_wdata_i,
  output logic [7:0]        mem_rdata_o,
  output logic [RAM_AW-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  mc_state_e         state_r;
  mc_state_e         state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [7:0]        b0_r;
  logic [7:0]        b1_r;
  logic [7:0]        b2_r;
  logic [31:0]       inst_r;
  logic              done_r;
  logic              abort_s;
  logic [RAM_AW-1:0] fetch_a_s;
  logic              unused_s;

  // Upper MEM address bits are intentionally dropped by the RAM port.
  assign unused_s = ^mem_addr_i[ADDR_W-1:RAM_AW];

  // A fetch in flight is abandoned on MEM priority, request drop or redirect.
  assign abort_s = mem_req_i | ~if_req_i | (if_addr_i != pc_r);

  // Low bits of pc+k equal (low bits of pc)+k, so the modular wrap is implicit.
  assign fetch_a_s = pc_r[RAM_AW-1:0] + RAM_AW'(fetch_offset(state_r));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one address per cycle, abort back to IDLE before DONE.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (if_req_i && !mem_req_i) begin
          state_nxt_s = ST_A0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_A0: begin
        if (abort_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_A1;
      end
      ST_A1: begin
        if (abort_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_A2;
      end
      ST_A2: begin
        if (abort_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_A3;
      end
      ST_A3: begin
        if (abort_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_W;
      end
      ST_W: begin
        if (abort_s) state_nxt_s = ST_IDLE;
        else         state_nxt_s = ST_DONE;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Fetch datapath: latch PC on start, capture bytes a cycle after each address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r   <= {ADDR_W{1'b0}};
      b0_r   <= 8'h00;
      b1_r   <= 8'h00;
      b2_r   <= 8'h00;
      inst_r <= 32'h0000_0000;
      done_r <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == ST_DONE);
      if (state_r == ST_IDLE && state_nxt_s == ST_A0) begin
        pc_r <= if_addr_i;
      end
      case (state_r)
        ST_A1:   b0_r <= ram_din_i;
        ST_A2:   b1_r <= ram_din_i;
        ST_A3:   b2_r <= ram_din_i;
        ST_W: begin
          if (state_nxt_s == ST_DONE) begin
            inst_r <= {ram_din_i, b2_r, b1_r, b0_r};
          end
        end
        default: ;
      endcase
    end
  end

  // RAM port mux: MEM passes through combinationally, else the fetch FSM.
  always_comb begin
    ram_a_o    = {RAM_AW{1'b0}};
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'h00;
    if (rst) begin
      ram_a_o    = {RAM_AW{1'b0}};
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'h00;
    end else if (mem_req_i) begin
      ram_a_o    = mem_addr_i[RAM_AW-1:0];
      ram_wr_o   = mem_we_i;
      ram_dout_o = mem_wdata_i;
    end else if (fetch_drives(state_r)) begin
      ram_a_o    = fetch_a_s;
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'h00;
    end else begin
      ram_a_o    = {RAM_AW{1'b0}};
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'h00;
    end
  end

  assign mem_rdata_o = ram_din_i;
  assign if_inst_o   = inst_r;
  assign if_done_o   = done_r;

endmodule
